phy_link_rx: RTL and testbench
==============================

// Module: phy_link_rx
// PURPOSE
//  Receive side of the inter-node physical link, directly downstream of the serialising phy.
//  Samples the 8-bit serial bus on each byte strobe and re-assembles 4 bytes (MSB first) into a 32-bit flit.
//  Completed flits are buffered in a FIFO and handed to the network node over a valid/ready interface.
//  Fully synchronous to clk; the strobe is synchronised internally; detects overflow and broken frames.
// PARAMETERS
//  DEPTH        8   flit FIFO entries (power of 2, >=2)
//  TIMEOUT      64  max clk cycles between bytes of one flit before the partial flit is discarded
//  SYNC_STAGES  2   synchroniser flops on link_strobe (>=2)
// PORTS
//  clk                    in   1   system clock
//  rst                    in   1   synchronous, active-high reset
//  link_strobe            in   1   byte strobe from remote phy (its write_req_send); each 0->1 carries one byte
//  serial_data_in         in   8   byte lane from remote phy; stable >= SYNC_STAGES+2 cycles after strobe rise
//  link_ready             out  1   1 = FIFO not full, remote may send a flit (drives remote read_ready)
//  output_data_to_router  out  32  head flit of FIFO
//  out_valid              out  1   head flit valid (FIFO not empty)
//  out_ready              in   1   network node accepts head flit when out_valid & out_ready
//  fifo_level             out  $clog2(DEPTH)+1  entries currently held
//  overflow               out  1   sticky: a completed flit was dropped because FIFO was full
//  frame_error            out  1   one-cycle pulse: partial flit discarded on inter-byte timeout
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): FIFO emptied, state=IDLE, byte_cnt=0, timer=0; outputs: link_ready=1,
//   out_valid=0, output_data_to_router=0, fifo_level=0, overflow=0, frame_error=0.
//   Sync chain and edge-history flop reset to 1: a strobe held high across reset is NOT counted as a byte.
//  Edge detect: byte_evt = sync_last & ~history; one byte per rising edge; level/high time ignored.
//   Cycle with byte_evt=1 is "cycle E"; serial_data_in sampled in cycle E.
//  FSM (byte position): IDLE(0) -> B1 -> B2 -> B3, advancing on each byte_evt.
//   IDLE: byte -> shreg[31:24]; B1 -> [23:16]; B2 -> [15:8]; B3: word={shreg[31:8],byte} pushed, -> IDLE.
//  Push happens in cycle E of 4th byte; out_valid rises at E+1 if FIFO was empty (strobe->valid = SYNC_STAGES+2 clk).
//  FIFO: show-ahead; output_data_to_router = mem[rd_ptr]; pop on out_valid & out_ready; ptrs wrap mod DEPTH.
//   Push and pop in same cycle: both performed, fifo_level unchanged (allowed also when full at cycle start? NO:
//   push is accepted only if fifo_level < DEPTH at start of cycle; a simultaneous pop does not free the slot).
//  Overflow: 4th byte arrives with FIFO full -> flit dropped, FIFO untouched, overflow<=1 until rst, FSM -> IDLE.
//  link_ready = (fifo_level != DEPTH), combinational from level; remote must not start a flit while 0.
//  Timeout: timer cleared on every byte_evt and in IDLE; counts in B1..B3; when timer==TIMEOUT-1 without byte:
//   shreg discarded, FSM -> IDLE, frame_error=1 for exactly one cycle. byte_evt in that same cycle wins (no error).
//  out_valid / data must hold stable while out_ready=0; popping empty FIFO is ignored.
//  Widths: fifo_level range 0..DEPTH; timer width $clog2(TIMEOUT)+1; no arithmetic on data.
// TESTING
//  T1 rst, send bytes A1,B2,C3,D4 -> one flit 32'hA1B2C3D4, out_valid at SYNC_STAGES+2 clk after 4th strobe rise.
//  T2 out_ready=0, send DEPTH+1 flits -> link_ready=0 after 8th, 9th dropped, overflow=1 sticky; drain gives 8 flits in order.
//  T3 send 2 bytes then idle TIMEOUT cycles -> frame_error single pulse, next 4 bytes 11,22,33,44 yield 32'h11223344.
//  T4 FIFO full, out_ready=1 in cycle E of 4th byte -> pop occurs, new flit dropped, overflow=1, level=DEPTH-1.
//  T5 continuous streaming with out_ready=1, 100 flits incrementing -> all received in order, fifo_level<=1, no errors.
//  T6 assert rst after 3 bytes with strobe held high -> level=0, no byte counted at release; next 4 bytes form clean flit.

Source files
------------

// File: rtl/phy_link_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_link_rx_if
// Brief    : Link-side byte lane plus node-side flit handshake of phy_link_rx.
// Revision : 1.0
// ============================================================================
interface phy_link_rx_if #(
    parameter int DEPTH = 8
) ();
    logic                     link_strobe;
    logic [7:0]               serial_data_in;
    logic                     link_ready;
    logic [31:0]              output_data_to_router;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     overflow;
    logic                     frame_error;

    // The master side feeds bytes and accepts flits.
    modport master (
        output link_strobe, serial_data_in, out_ready,
        input  link_ready, output_data_to_router, out_valid,
        input  fifo_level, overflow, frame_error
    );

    modport slave (
        input  link_strobe, serial_data_in, out_ready,
        output link_ready, output_data_to_router, out_valid,
        output fifo_level, overflow, frame_error
    );
endinterface
`default_nettype wire

// File: rtl/phy_link_rx.sv
`default_nettype none
// ============================================================================
// Module   : phy_link_rx
// Brief    : Serial byte-lane receiver; builds 32-bit flits into a show-ahead FIFO.
// Revision : 1.0
// ============================================================================
module phy_link_rx #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    phy_link_rx_if.slave     bus
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_LW = c_PW + 1;
    localparam int c_TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B1   = 2'd1,
        S_B2   = 2'd2,
        S_B3   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    state_t                 r_state;
    logic [23:0]            r_shreg;
    logic [c_TW-1:0]        r_timer;
    logic                   r_overflow;
    logic                   r_frame_error;
    logic [31:0]            r_mem [DEPTH];
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW-1:0]        r_rd_ptr;
    logic [c_LW-1:0]        r_level;

    logic        w_byte_evt;
    logic        w_full;
    logic        w_last;
    logic        w_push;
    logic        w_pop;
    logic        w_timeout;
    logic [31:0] w_word;

    // Reset to 1 so a strobe already high at reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.link_strobe};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_byte_evt = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_full     = (r_level == c_LW'(DEPTH));
    assign w_last     = w_byte_evt && (r_state == S_B3);
    assign w_push     = w_last && !w_full;
    assign w_pop      = (r_level != '0) && bus.out_ready;
    assign w_word     = {r_shreg, bus.serial_data_in};
    assign w_timeout  = (r_state != S_IDLE) && !w_byte_evt &&
                        (r_timer == c_TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shreg       <= '0;
            r_timer       <= '0;
            r_overflow    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_timeout;
            if (w_byte_evt) begin
                r_timer <= '0;
                case (r_state)
                    S_IDLE: begin r_shreg[23:16] <= bus.serial_data_in; r_state <= S_B1; end
                    S_B1:   begin r_shreg[15:8]  <= bus.serial_data_in; r_state <= S_B2; end
                    S_B2:   begin r_shreg[7:0]   <= bus.serial_data_in; r_state <= S_B3; end
                    S_B3: begin
                        r_state <= S_IDLE;
                        if (w_full) r_overflow <= 1'b1;
                    end
                endcase
            end else if (w_timeout) begin
                r_state <= S_IDLE;
                r_shreg <= '0;
                r_timer <= '0;
            end else if (r_state == S_IDLE) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_word;
    end

    // A full FIFO rejects the push even when the same cycle pops the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign bus.link_ready            = !w_full;
    assign bus.out_valid             = (r_level != '0);
    assign bus.output_data_to_router = (r_level != '0) ? r_mem[r_rd_ptr] : 32'h0;
    assign bus.fifo_level            = r_level;
    assign bus.overflow              = r_overflow;
    assign bus.frame_error           = r_frame_error;
endmodule
`default_nettype wire

// File: tb/tb_phy_link_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_link_rx
// Brief    : Directed self-checking bench for phy_link_rx.
// Revision : 1.0
// ============================================================================
module tb_phy_link_rx;
    localparam int DEPTH       = 8;
    localparam int TIMEOUT     = 64;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   fe_cnt;
    int   max_level;
    logic [31:0] rx_q [$];

    phy_link_rx_if #(.DEPTH(DEPTH)) bus ();

    phy_link_rx #(
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Records every accepted flit, frame-error cycle and peak level, mid low phase.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) rx_q.push_back(bus.output_data_to_router);
            if (bus.frame_error) fe_cnt++;
            if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        fe_cnt    = 0;
        max_level = 0;
        @(negedge clk);
    endtask

    // lat = first negedge index after strobe rise at which out_valid is seen.
    task automatic send_byte(input logic [7:0] b, input bit pulse_ready, output int lat);
        lat = -1;
        bus.serial_data_in = b;
        bus.link_strobe    = 1'b1;
        for (int i = 1; i <= SYNC_STAGES + 3; i++) begin
            @(negedge clk);
            if (pulse_ready) bus.out_ready = (i == SYNC_STAGES);
            if (lat < 0 && bus.out_valid) lat = i;
        end
        bus.link_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_flit(input logic [31:0] w, output int lat);
        int l;
        send_byte(w[31:24], 1'b0, l);
        send_byte(w[23:16], 1'b0, l);
        send_byte(w[15:8],  1'b0, l);
        send_byte(w[7:0],   1'b0, lat);
    endtask

    initial begin
        int lat;
        logic [31:0] w;
        rst = 1'b1;
        bus.link_strobe    = 1'b0;
        bus.serial_data_in = 8'h00;
        bus.out_ready      = 1'b0;

        // T1: reset state, single flit and strobe-to-valid latency
        do_reset();
        check("rst_level", 32'(bus.fifo_level), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_data", bus.output_data_to_router, 32'h0);
        check("rst_link_ready", 32'(bus.link_ready), 1);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_frame_error", 32'(bus.frame_error), 0);
        send_flit(32'hA1B2C3D4, lat);
        check("t1_latency_ok", 32'(lat >= SYNC_STAGES + 1 && lat <= SYNC_STAGES + 2), 1);
        check("t1_head", bus.output_data_to_router, 32'hA1B2C3D4);
        check("t1_level", 32'(bus.fifo_level), 1);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;
        check("t1_rx_count", 32'(rx_q.size()), 1);
        check("t1_rx_word", rx_q[0], 32'hA1B2C3D4);
        check("t1_empty_valid", 32'(bus.out_valid), 0);

        // T2: fill, overflow on the ninth flit, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)};
            send_flit(w, lat);
            if (i == DEPTH - 1) begin
                check("t2_full_link_ready", 32'(bus.link_ready), 0);
                check("t2_full_overflow", 32'(bus.overflow), 0);
            end
        end
        check("t2_overflow", 32'(bus.overflow), 1);
        check("t2_level", 32'(bus.fifo_level), DEPTH);
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        bus.out_ready = 1'b0;
        check("t2_rx_count", 32'(rx_q.size()), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            check("t2_rx_word", rx_q[i], {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)});
        check("t2_overflow_sticky", 32'(bus.overflow), 1);
        check("t2_drained_link_ready", 32'(bus.link_ready), 1);

        // T3: inter-byte timeout discards a partial flit
        do_reset();
        bus.out_ready = 1'b1;
        send_byte(8'hAA, 1'b0, lat);
        send_byte(8'hBB, 1'b0, lat);
        repeat (TIMEOUT + 5) @(negedge clk);
        check("t3_fe_pulses", 32'(fe_cnt), 1);
        check("t3_level", 32'(bus.fifo_level), 0);
        send_flit(32'h11223344, lat);
        repeat (2) @(negedge clk);
        check("t3_rx_count", 32'(rx_q.size()), 1);
        check("t3_rx_word", rx_q[0], 32'h11223344);
        check("t3_fe_after", 32'(fe_cnt), 1);
        bus.out_ready = 1'b0;

        // T4: pop in the cycle of the 4th byte does not free a slot for it
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_flit(32'hC0000000 + 32'(i), lat);
        send_byte(8'hDE, 1'b0, lat);
        send_byte(8'hAD, 1'b0, lat);
        send_byte(8'hBE, 1'b0, lat);
        send_byte(8'hEF, 1'b1, lat);
        check("t4_level", 32'(bus.fifo_level), DEPTH - 1);
        check("t4_overflow", 32'(bus.overflow), 1);
        check("t4_popped", 32'(rx_q.size()), 1);
        check("t4_popped_word", rx_q[0], 32'hC0000000);
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        bus.out_ready = 1'b0;
        check("t4_rx_count", 32'(rx_q.size()), DEPTH);
        check("t4_last_word", rx_q[DEPTH - 1], 32'hC0000007);

        // T5: continuous streaming with the node always ready
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) send_flit(32'h0A0B0000 + 32'(k), lat);
        repeat (4) @(negedge clk);
        check("t5_rx_count", 32'(rx_q.size()), 100);
        for (int k = 0; k < 100 && k < rx_q.size(); k++)
            check("t5_rx_word", rx_q[k], 32'h0A0B0000 + 32'(k));
        check("t5_max_level_le1", 32'(max_level <= 1), 1);
        check("t5_fe", 32'(fe_cnt), 0);
        check("t5_overflow", 32'(bus.overflow), 0);
        bus.out_ready = 1'b0;

        // T6: reset mid-flit with the strobe held high across release
        do_reset();
        send_byte(8'h77, 1'b0, lat);
        send_byte(8'h88, 1'b0, lat);
        bus.serial_data_in = 8'h99;
        bus.link_strobe    = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        repeat (5) @(negedge clk);
        check("t6_level", 32'(bus.fifo_level), 0);
        check("t6_valid", 32'(bus.out_valid), 0);
        bus.link_strobe = 1'b0;
        repeat (3) @(negedge clk);
        send_flit(32'hCAFEF00D, lat);
        check("t6_level_after", 32'(bus.fifo_level), 1);
        check("t6_head", bus.output_data_to_router, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
